seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Inverse companion to the team's combinational ripple-carry adder. Each iteration is a trial subtraction built from the same add-with-carry logic.
- Sits behind the board switch/button input logic. Results drive the LED/7-segment display path.
- Uses a start/busy/done handshake so slow front-panel logic can launch one operation and collect the result.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 29 ++
 rtl/seq_divider_div_step.sv | 44 ++++
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: FSM encoding and default width.
package seq_divider_pkg;

    // Default operand width, also used by the display path.
    localparam int DEFAULT_WIDTH = 4;

    // FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle between front-panel logic and the divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    // Requester side: launches operations and collects results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the
// divisor with a ripple-carry adder (inverted divisor, carry-in 1), keep or restore.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] pr,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] pr_next,
    output logic             q_bit
);

    // Shifted partial remainder and the one's complement of the zero-extended divisor.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] neg_div;
    logic [WIDTH:0] diff;

    assign shifted = {pr, bit_in};
    assign neg_div = ~{1'b0, divisor};

    // WIDTH+1-bit ripple-carry adder; each cell derives its carry-in from the
    // previous cell so the chain stays a plain per-bit structure.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_bit
            logic c_in;
            if (gi == 0) begin : g_first
                assign c_in = 1'b1;
            end else begin : g_rest
                assign c_in = (shifted[gi-1] & neg_div[gi-1]) |
                              (g_bit[gi-1].c_in & (shifted[gi-1] ^ neg_div[gi-1]));
            end
            assign diff[gi] = shifted[gi] ^ neg_div[gi] ^ c_in;
        end
    endgenerate

    // Non-negative difference means the divisor fits. The kept value always
    // stays below 2^WIDTH because the partial remainder never reaches the divisor.
    assign q_bit   = ~diff[WIDTH];
    assign pr_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Results are held until the next completion.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] pr_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    logic [WIDTH-1:0] pr_step;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr      (pr_reg),
        .bit_in  (shift_reg[WIDTH-1]),
        .divisor (divisor_reg),
        .pr_next (pr_step),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (count_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.busy = (state_reg != IDLE);
        bus.done = (state_reg == DONE);
    end

    // Datapath: operand capture, one iteration per CALC cycle, result capture on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= '0;
            shift_reg       <= '0;
            divisor_reg     <= '0;
            pr_reg          <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg   <= bus.dividend;
                        divisor_reg <= bus.divisor;
                        pr_reg      <= '0;
                        count_reg   <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    pr_reg    <= pr_step;
                    shift_reg <= {shift_reg[WIDTH-2:0], q_bit};
                    if (count_reg == '0) begin
                        quotient_reg    <= {shift_reg[WIDTH-2:0], q_bit};
                        remainder_reg   <= pr_step;
                        div_by_zero_reg <= (divisor_reg == '0);
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=4 and WIDTH=8: drivers push expected
// results (plain / and %), monitors pop and compare whenever done is seen.
module tb_seq_divider;

    typedef struct {
        int q;
        int r;
        int dbz;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q4[$];
    exp_t q8[$];

    int held4_q = 0, held4_r = 0, held4_dbz = 0;
    int held8_q = 0, held8_r = 0, held8_dbz = 0;

    seq_divider_if #(.WIDTH(4)) if4 ();
    seq_divider_if #(.WIDTH(8)) if8 ();

    seq_divider #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    seq_divider #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: quotient/remainder by arithmetic; divide by zero gives all ones / dividend.
    function automatic exp_t model(input int a, input int b, input int w, input int c);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << w) - 1;
            e.r = a;
            e.dbz = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 0;
        end
        e.cyc = c;
        return e;
    endfunction

    // Monitor for the WIDTH=4 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            held4_q = 0; held4_r = 0; held4_dbz = 0;
        end else if (if4.done) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL w4_unexpected_done got q=%0d r=%0d at cyc=%0d required no done",
                         if4.quotient, if4.remainder, cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                if (int'(if4.quotient) != e.q || int'(if4.remainder) != e.r ||
                    int'(if4.div_by_zero) != e.dbz || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL w4_result got q=%0d r=%0d dbz=%0d cyc=%0d required q=%0d r=%0d dbz=%0d cyc=%0d",
                             if4.quotient, if4.remainder, if4.div_by_zero, cyc, e.q, e.r, e.dbz, e.cyc);
                end else begin
                    $display("w4 done q=%0d r=%0d dbz=%0d cyc=%0d ok", e.q, e.r, e.dbz, cyc);
                end
                held4_q = e.q; held4_r = e.r; held4_dbz = e.dbz;
            end
        end else begin
            checks++;
            if (int'(if4.quotient) != held4_q || int'(if4.remainder) != held4_r ||
                int'(if4.div_by_zero) != held4_dbz) begin
                errors++;
                $display("FAIL w4_hold got q=%0d r=%0d dbz=%0d required q=%0d r=%0d dbz=%0d cyc=%0d",
                         if4.quotient, if4.remainder, if4.div_by_zero, held4_q, held4_r, held4_dbz, cyc);
            end
        end
    end

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            held8_q = 0; held8_r = 0; held8_dbz = 0;
        end else if (if8.done) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done got q=%0d r=%0d at cyc=%0d required no done",
                         if8.quotient, if8.remainder, cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if (int'(if8.quotient) != e.q || int'(if8.remainder) != e.r ||
                    int'(if8.div_by_zero) != e.dbz || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL w8_result got q=%0d r=%0d dbz=%0d cyc=%0d required q=%0d r=%0d dbz=%0d cyc=%0d",
                             if8.quotient, if8.remainder, if8.div_by_zero, cyc, e.q, e.r, e.dbz, e.cyc);
                end else begin
                    $display("w8 done q=%0d r=%0d dbz=%0d cyc=%0d ok", e.q, e.r, e.dbz, cyc);
                end
                held8_q = e.q; held8_r = e.r; held8_dbz = e.dbz;
            end
        end else begin
            checks++;
            if (int'(if8.quotient) != held8_q || int'(if8.remainder) != held8_r ||
                int'(if8.div_by_zero) != held8_dbz) begin
                errors++;
                $display("FAIL w8_hold got q=%0d r=%0d dbz=%0d required q=%0d r=%0d dbz=%0d cyc=%0d",
                         if8.quotient, if8.remainder, if8.div_by_zero, held8_q, held8_r, held8_dbz, cyc);
            end
        end
    end

    // Launch one WIDTH=4 operation at the first idle negedge; scrambles operands after accept.
    task automatic op4(input int a, input int b);
        int guard = 0;
        while (if4.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL w4_wait_idle got busy=%0d required busy=0 within 100 cycles", if4.busy);
        end
        if4.start    = 1'b1;
        if4.dividend = 4'(a);
        if4.divisor  = 4'(b);
        q4.push_back(model(a, b, 4, cyc + 1 + 4));
        @(negedge clk);
        if4.start    = 1'b0;
        if4.dividend = 4'($urandom);
        if4.divisor  = 4'($urandom);
        checks++;
        if (if4.busy !== 1'b1) begin
            errors++;
            $display("FAIL w4_busy_after_start got busy=%0d required busy=1", if4.busy);
        end
    endtask

    task automatic op8(input int a, input int b);
        int guard = 0;
        while (if8.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL w8_wait_idle got busy=%0d required busy=0 within 100 cycles", if8.busy);
        end
        if8.start    = 1'b1;
        if8.dividend = 8'(a);
        if8.divisor  = 8'(b);
        q8.push_back(model(a, b, 8, cyc + 1 + 8));
        @(negedge clk);
        if8.start    = 1'b0;
        if8.dividend = 8'($urandom);
        if8.divisor  = 8'($urandom);
        checks++;
        if (if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL w8_busy_after_start got busy=%0d required busy=1", if8.busy);
        end
    endtask

    // Wait (bounded) until every issued operation has been collected and both DUTs are idle.
    task automatic drain();
        int guard = 0;
        while ((q4.size() != 0 || q8.size() != 0 || if4.busy || if8.busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL drain got pending4=%0d pending8=%0d required 0 within 200 cycles",
                     q4.size(), q8.size());
        end
    endtask

    initial begin
        if4.start = 1'b0; if4.dividend = '0; if4.divisor = '0;
        if8.start = 1'b0; if8.dividend = '0; if8.divisor = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: handshake outputs stay low (result hold is checked by the monitors).
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if8.busy !== 1'b0 || if8.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset got busy4=%0d done4=%0d busy8=%0d done8=%0d required all 0",
                         if4.busy, if4.done, if8.busy, if8.done);
            end
        end

        // Directed WIDTH=4 cases, back to back at the earliest legal accept.
        op4(13, 3);
        op4(15, 1);
        op4(2, 3);
        op4(7, 0);
        op4(9, 4);
        drain();

        // Start while busy: second request lands at E2 and must be ignored.
        op4(13, 3);
        @(negedge clk);
        if4.start = 1'b1; if4.dividend = 4'd6; if4.divisor = 4'd2;
        @(negedge clk);
        if4.start = 1'b0;
        drain();

        // Reset mid-operation: outputs clear immediately, no done for the aborted run.
        op4(14, 5);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q4.delete();
        #1;
        checks++;
        if (if4.quotient !== 4'd0 || if4.remainder !== 4'd0 || if4.busy !== 1'b0 ||
            if4.done !== 1'b0 || if4.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL w4_async_reset got q=%0d r=%0d busy=%0d done=%0d dbz=%0d required all 0",
                     if4.quotient, if4.remainder, if4.busy, if4.done, if4.div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op4(14, 5);
        drain();

        // WIDTH=8 directed then random traffic on both widths.
        op8(255, 16);
        op8(0, 0);
        op8(200, 0);
        drain();
        for (int i = 0; i < 40; i++) op4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        drain();
        for (int i = 0; i < 30; i++) op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if something wedges the stimulus thread.
    initial begin
        #200000;
        $display("FAIL watchdog got no completion required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
